// File: rtl/nios2_mem_pkg.sv
// Shared constants and types for the Nios II on-chip memory arbiter.
package nios2_mem_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  // Read-return tag: one outstanding read, tagged with the requester index.
  typedef struct packed {
    logic vld;
    logic idx;
  } ret_tag_t;

endpackage

// File: rtl/nios2_rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins, contention goes to the
// requester that was not granted last.
module nios2_rr_arbiter2
  import nios2_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (&req) begin
      grant = (last_grant == REQ_DMA) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/nios2_onchip_mem_arbiter.sv
// Shares one single-port on-chip RAM between the CPU and DMA Avalon-MM
// requesters; reads return one cycle after acceptance.
module nios2_onchip_mem_arbiter
  import nios2_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic [ADDR_W-1:0]   s0_address,
  input  logic [DATA_W/8-1:0] s0_byteenable,
  input  logic                s0_read,
  input  logic                s0_write,
  input  logic [DATA_W-1:0]   s0_writedata,
  output logic                s0_waitrequest,
  output logic                s0_readdatavalid,
  output logic [DATA_W-1:0]   s0_readdata,

  input  logic [ADDR_W-1:0]   s1_address,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic                s1_waitrequest,
  output logic                s1_readdatavalid,
  output logic [DATA_W-1:0]   s1_readdata,

  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata,

  output logic [15:0]         dbg_s0_cmd_count,
  output logic [15:0]         dbg_s1_cmd_count
);

  logic        rel_q;
  logic        last_grant_q;
  ret_tag_t    tag_p1;
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  logic [1:0]  req;
  logic [1:0]  grant;
  logic        gidx;
  logic        acc;

  // Requests are masked until the cycle after reset release.
  assign req = {s1_read | s1_write, s0_read | s0_write} & {2{rel_q}};

  nios2_rr_arbiter2 u_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign gidx = grant[1];
  assign acc  = |grant;

  assign s0_waitrequest = ~grant[0];
  assign s1_waitrequest = ~grant[1];

  // Stage p0: granted command steered straight onto the RAM port
  assign ram_address    = gidx ? s1_address    : s0_address;
  assign ram_byteenable = gidx ? s1_byteenable : s0_byteenable;
  assign ram_writedata  = gidx ? s1_writedata  : s0_writedata;
  assign ram_chipselect = acc;
  assign ram_write      = acc & (gidx ? s1_write : s0_write);
  assign ram_clken      = reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rel_q        <= 1'b0;
      last_grant_q <= REQ_DMA;
      tag_p1       <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      rel_q      <= 1'b1;
      if (acc) begin
        last_grant_q <= gidx;
      end
      // A read+write command is a write, so only pure reads get a tag.
      tag_p1.vld <= acc & ~ram_write;
      tag_p1.idx <= gidx;
      if (grant[0]) cnt0_q <= cnt0_q + 16'd1;
      if (grant[1]) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  // Stage p1: RAM data returned to the tagged requester
  assign s0_readdatavalid = tag_p1.vld & (tag_p1.idx == REQ_CPU);
  assign s1_readdatavalid = tag_p1.vld & (tag_p1.idx == REQ_DMA);
  assign s0_readdata      = ram_readdata;
  assign s1_readdata      = ram_readdata;

  assign dbg_s0_cmd_count = cnt0_q;
  assign dbg_s1_cmd_count = cnt1_q;

endmodule
